// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM line,
// converts the ratio to a 0..STEPS duty step and flags a stuck line.
module pwm_capture #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535,
    parameter int STEPS   = 10
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_PWM,
    output logic [CNT_W-1:0] o_Period,
    output logic [CNT_W-1:0] o_High,
    output logic             o_Valid,
    output logic [3:0]       o_Duty_Step,
    output logic             o_Step_Valid,
    output logic             o_Stuck,
    output logic             o_Level
);

    localparam int              TW      = CNT_W + 4;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       STEPS_4 = 4'(STEPS);

    typedef enum logic {M_IDLE, M_MEASURE} m_state_t;
    typedef enum logic {S_DONE, S_CALC}    s_state_t;

    m_state_t m_state, m_next;
    s_state_t s_state, s_next;

    logic             s1, s2, s3;
    logic [CNT_W-1:0] per_cnt, hi_cnt;
    logic [TW-1:0]    target, acc;
    logic [CNT_W-1:0] div;
    logic [3:0]       k;

    logic             rise, to_evt, capture, stuck_evt, calc_step;
    logic [TW:0]      sum;

    assign rise      = s2 & ~s3;
    // per_cnt doubles as the idle counter while in M_IDLE
    assign to_evt    = ~rise & (per_cnt == TO_VAL);
    assign capture   = rise & (m_state == M_MEASURE);
    // an already-stuck line only restarts the idle counter, no new pulses
    assign stuck_evt = to_evt & ~((m_state == M_IDLE) & o_Stuck);
    assign sum       = {1'b0, acc} + {5'b0, div};
    assign calc_step = (k < STEPS_4) && (sum <= {1'b0, target});

    // Synchronizer plus edge-detect flop
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= i_PWM;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Measure FSM state register
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) m_state <= M_IDLE;
        else          m_state <= m_next;
    end

    // Measure FSM next state; rise has priority over timeout
    always_comb begin
        m_next = m_state;
        case (m_state)
            M_IDLE:    if (rise)   m_next = M_MEASURE;
            M_MEASURE: if (to_evt) m_next = M_IDLE;
            default:   m_next = M_IDLE;
        endcase
    end

    // Counters and measurement / stuck outputs
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            per_cnt  <= '0;
            hi_cnt   <= '0;
            o_Period <= '0;
            o_High   <= '0;
            o_Valid  <= 1'b0;
            o_Stuck  <= 1'b0;
            o_Level  <= 1'b0;
        end else begin
            o_Valid <= capture;
            if (rise) begin
                per_cnt <= CNT_W'(1);
                hi_cnt  <= CNT_W'(1);
            end else begin
                if (to_evt)                per_cnt <= '0;
                else if (per_cnt != TO_VAL) per_cnt <= per_cnt + 1'b1;
                if (s2 && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + 1'b1;
            end
            if (capture) begin
                o_Period <= per_cnt;
                o_High   <= hi_cnt;
                o_Stuck  <= 1'b0;
            end else if (stuck_evt) begin
                o_Period <= '0;
                o_High   <= '0;
                o_Stuck  <= 1'b1;
                o_Level  <= s2;
            end
        end
    end

    // Step FSM state register
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) s_state <= S_DONE;
        else          s_state <= s_next;
    end

    // Step FSM next state; a new capture restarts, a timeout aborts
    always_comb begin
        s_next = s_state;
        if (stuck_evt)                          s_next = S_DONE;
        else if (capture)                       s_next = S_CALC;
        else if (s_state == S_CALC && !calc_step) s_next = S_DONE;
    end

    // Serial divide: count how many periods fit into high*STEPS
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            target       <= '0;
            acc          <= '0;
            div          <= '0;
            k            <= '0;
            o_Duty_Step  <= '0;
            o_Step_Valid <= 1'b0;
        end else begin
            o_Step_Valid <= 1'b0;
            if (stuck_evt) begin
                o_Duty_Step  <= s2 ? STEPS_4 : 4'd0;
                o_Step_Valid <= 1'b1;
            end else if (capture) begin
                target <= {4'b0, hi_cnt} * TW'(STEPS);
                div    <= per_cnt;
                acc    <= '0;
                k      <= '0;
            end else if (s_state == S_CALC) begin
                if (calc_step) begin
                    acc <= sum[TW-1:0];
                    k   <= k + 4'd1;
                end else begin
                    o_Duty_Step  <= k;
                    o_Step_Valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: behavioural PWM source, hand-computed checks.
module tb_pwm_capture;

    localparam int CNT_W = 16;

    logic             i_Clk = 1'b0;
    logic             i_Rst_n = 1'b0;
    logic             i_PWM = 1'b0;
    logic [CNT_W-1:0] o_Period, o_High;
    logic             o_Valid, o_Step_Valid, o_Stuck, o_Level;
    logic [3:0]       o_Duty_Step;

    int n_cmp = 0, n_err = 0;
    int sv_cnt = 0, v_cnt = 0;

    // PWM source: mode 0 = pwm, 1 = held low, 2 = held high
    int mode = 1;
    int gcnt = 9, cur_hi = 5, cur_per = 10, nxt_hi = 5, nxt_per = 10;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(64), .STEPS(10)) dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_PWM(i_PWM),
        .o_Period(o_Period), .o_High(o_High), .o_Valid(o_Valid),
        .o_Duty_Step(o_Duty_Step), .o_Step_Valid(o_Step_Valid),
        .o_Stuck(o_Stuck), .o_Level(o_Level)
    );

    always #5 i_Clk = ~i_Clk;

    // Line driver; new high/period take effect at a period boundary
    initial begin
        forever begin
            @(negedge i_Clk);
            if (mode == 0) begin
                if (gcnt >= cur_per - 1) begin
                    gcnt = 0; cur_hi = nxt_hi; cur_per = nxt_per;
                end else begin
                    gcnt++;
                end
                i_PWM = (gcnt < cur_hi);
            end else begin
                i_PWM = (mode == 2);
                gcnt  = cur_per - 1;
            end
        end
    end

    // Pulse counters
    always @(negedge i_Clk) begin
        if (o_Step_Valid) sv_cnt++;
        if (o_Valid)      v_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Wait for o_Valid (stp=0) or o_Step_Valid (stp=1), bounded
    task automatic wait_sig(input bit stp, input int budget, input string tag, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge i_Clk);
            n++;
            if (stp ? o_Step_Valid : o_Valid) return;
        end
        chk({tag, "_timeout"}, stp ? o_Step_Valid : o_Valid, 1);
    endtask

    function automatic logic [63:0] all_out();
        return {24'd0, o_Period, o_High, o_Valid, o_Duty_Step, o_Step_Valid, o_Stuck, o_Level};
    endfunction

    int n;
    int seq[3] = '{6, 7, 6};

    initial begin
        repeat (4) @(negedge i_Clk);
        chk("reset_outs", all_out(), 0);
        i_Rst_n = 1'b1;
        @(negedge i_Clk);
        chk("post_reset_outs", all_out(), 0);

        // loopback 5/10
        mode = 0;
        wait_sig(0, 40, "first_valid", n);
        chk("p10_period", o_Period, 10);
        chk("p10_high", o_High, 5);
        @(negedge i_Clk);
        chk("valid_one_cycle", o_Valid, 0);
        wait_sig(1, 11, "first_step", n);
        chk("p10_duty", o_Duty_Step, 5);
        wait_sig(0, 20, "steady", n);
        wait_sig(0, 20, "steady2", n);
        chk("steady_gap", n, 10);

        // stepped duty 6, 7, 6
        for (int i = 0; i < 3; i++) begin
            wait_sig(0, 20, "seq_sync", n);
            nxt_hi = seq[i];
            wait_sig(0, 20, "seq_old", n);
            wait_sig(0, 20, "seq_new", n);
            chk("seq_high", o_High, seq[i]);
            chk("seq_period", o_Period, 10);
            wait_sig(1, 11, "seq_step", n);
            chk("seq_duty", o_Duty_Step, seq[i]);
        end

        // high 3 of period 7 -> floor(30/7) = 4
        wait_sig(0, 20, "d37_sync", n);
        nxt_hi = 3; nxt_per = 7;
        wait_sig(0, 20, "d37_old", n);
        wait_sig(0, 20, "d37_new", n);
        chk("d37_high", o_High, 3);
        chk("d37_period", o_Period, 7);
        wait_sig(1, 11, "d37_step", n);
        chk("d37_duty", o_Duty_Step, 4);

        // stuck low: one timeout pulse, idle restart stays silent
        wait_sig(0, 20, "low_sync", n);
        mode = 1;
        repeat (15) @(negedge i_Clk);
        #2 sv_cnt = 0; v_cnt = 0;
        repeat (150) @(negedge i_Clk);
        chk("low_stuck", o_Stuck, 1);
        chk("low_level", o_Level, 0);
        chk("low_duty", o_Duty_Step, 0);
        chk("low_period", o_Period, 0);
        chk("low_high", o_High, 0);
        chk("low_step_pulses", sv_cnt, 1);
        chk("low_valid_pulses", v_cnt, 0);

        // resume 3/10
        nxt_hi = 3; nxt_per = 10;
        mode = 0;
        wait_sig(0, 40, "resume_valid", n);
        chk("resume_stuck", o_Stuck, 0);
        chk("resume_period", o_Period, 10);
        chk("resume_high", o_High, 3);
        wait_sig(1, 11, "resume_step", n);
        chk("resume_duty", o_Duty_Step, 3);

        // stuck high
        mode = 2;
        repeat (150) @(negedge i_Clk);
        chk("high_stuck", o_Stuck, 1);
        chk("high_level", o_Level, 1);
        chk("high_duty", o_Duty_Step, 10);
        chk("high_period", o_Period, 0);

        // reset while the divider is running
        nxt_hi = 5; nxt_per = 10;
        mode = 0;
        wait_sig(0, 40, "prerst_valid", n);
        repeat (2) @(negedge i_Clk);
        #2 i_Rst_n = 1'b0;
        #1 chk("async_reset_outs", all_out(), 0);
        repeat (3) @(negedge i_Clk);
        i_Rst_n = 1'b1;
        #2 sv_cnt = 0; v_cnt = 0;
        wait_sig(0, 40, "rst_valid", n);
        chk("rst_no_stale_step", sv_cnt, 0);
        chk("rst_period", o_Period, 10);
        chk("rst_high", o_High, 5);
        wait_sig(1, 11, "rst_step", n);
        chk("rst_duty", o_Duty_Step, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator.
- Samples an external PWM line and measures its period and high time in i_Clk cycles.
- Converts the measurement into a duty step 0..STEPS, matching the generator's 10%-per-step scale.
- Detects a line stuck at 0% or 100% duty by timeout. Used for loopback self-test and for reading PWM inputs from external boards.

Parameters:
- CNT_W, 16, width of the period and high-time counters and outputs.
- TIMEOUT, 65535, cycles without a rising edge before the line is declared stuck; must be ≤ 2^CNT_W-1 and ≥ 2.
- STEPS, 10, full-scale duty step value; must be ≤ 15.

Ports:
- i_Clk  input  1  system clock; all logic on its rising edge.
- i_Rst_n  input  1  reset, asynchronous assert, active-low.
- i_PWM  input  1  asynchronous PWM line.
- o_Period  output  CNT_W  last measured period in cycles (rising edge to rising edge).
- o_High  output  CNT_W  last measured high time in cycles.
- o_Valid  output  1  one-cycle pulse when o_Period/o_High update.
- o_Duty_Step  output  4  floor(STEPS*o_High/o_Period), or 0/STEPS when stuck.
- o_Step_Valid  output  1  one-cycle pulse when o_Duty_Step updates.
- o_Stuck  output  1  line has had no rising edge for TIMEOUT cycles.
- o_Level  output  1  synchronized line level at the moment o_Stuck was set.

Behaviour:
- Reset: all outputs 0; synchronizer flops 0; all counters 0; measure FSM in IDLE; step FSM in DONE.
- Input path: 2-flop synchronizer s1→s2, plus a third flop s3 for edge detection.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Latency from i_PWM to rise is 2–3 cycles.
- Measure FSM, states IDLE and MEASURE:
  - IDLE: on rise → MEASURE; per_cnt=1; hi_cnt=1; no output.
  - MEASURE, each cycle without rise:
    - per_cnt increments, saturating at TIMEOUT.
    - hi_cnt increments when s2=1, saturating at 2^CNT_W-1.
  - MEASURE with rise:
    - o_Period<=per_cnt; o_High<=hi_cnt; o_Valid=1 for exactly one cycle; o_Stuck<=0.
    - per_cnt<=1; hi_cnt<=1; start step FSM.
    - o_Period and o_High appear in the cycle after the rise sample.
  - Timeout, in either state: when per_cnt==TIMEOUT (MEASURE), or the idle counter reaches TIMEOUT with no rise (IDLE):
    - o_Stuck<=1; o_Level<=s2; o_Period<=0; o_High<=0.
    - o_Duty_Step<=(s2 ? STEPS : 0); o_Step_Valid pulses; o_Valid does not pulse.
    - Abort step FSM; → IDLE.
    - While stuck in IDLE, the idle counter restarts and the stuck outputs are held, with no repeated pulses.
  - Rise and timeout in the same cycle: rise wins.
- Step FSM, states DONE and CALC (serial divide by repeated addition):
  - Start: target=hi*STEPS (CNT_W+4 bits); acc=0; k=0; → CALC.
  - CALC, each cycle:
    - If k<STEPS and acc+period ≤ target: acc+=period; k++.
    - Otherwise: o_Duty_Step<=k; o_Step_Valid pulses; → DONE.
  - Completes in at most STEPS+1 cycles after start.
  - A new capture during CALC restarts the calculation with the new values; the old result is never published.
  - o_Duty_Step holds between updates.
- Degenerate lines:
  - Period 1 (toggling every cycle) cannot occur after the synchronizer; minimum period is 2.
  - hi_cnt ≤ per_cnt always, so the result is ≤ STEPS.
- Reset asserted mid-operation: every register returns to its reset value immediately; the first valid result requires two rising edges after release.

Test Plan:
- Loopback from the PWM generator at duty 5, period 10, with TIMEOUT=64 → after the second rise:
  - o_Valid pulses with o_Period=10, o_High=5.
  - o_Step_Valid pulses within 11 cycles with o_Duty_Step=5.
  - Then steady pulses every 10 cycles.
- Stepped duty 5→6→7→6 driven by the generator → o_Duty_Step follows 6,7,6 within one period plus 11 cycles of each change; o_Period stays 10.
- Directed waveform with high 3 of period 7 → o_High=3, o_Period=7, o_Duty_Step=4 (floor of 30/7).
- Line held low 100 cycles with TIMEOUT=64:
  - o_Stuck=1, o_Level=0, o_Duty_Step=0, o_Period=0; exactly one o_Step_Valid pulse.
  - Resuming duty 3/10: o_Stuck clears on the first o_Valid, with o_Duty_Step=3.
- Line held high 100 cycles with TIMEOUT=64 → o_Stuck=1, o_Level=1, o_Duty_Step=10.
- Reset mid-operation:
  - Assert i_Rst_n=0 mid-period during CALC → all outputs 0 asynchronously, with no stale o_Step_Valid after release.
  - After release: the first rise gives no o_Valid; the second rise gives the correct o_Valid.
